// File: rtl/axi_stream_1_to_n_switch_if.sv
// Bus bundle for the 1-to-N AXI-Stream switch: one input stream,
// NUM_OUTPUTS packed output streams and the drop counter.
`timescale 1ns/1ps
interface axi_stream_1_to_n_switch_if #(
    parameter int NUM_OUTPUTS      = 4,
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_TID_WIDTH   = 1,
    parameter int AXIS_TDEST_WIDTH = 4,
    parameter int AXIS_TUSER_WIDTH = 1,
    parameter int DROP_CNT_WIDTH   = 16
);
    logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata;
    logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep;
    logic [AXIS_TID_WIDTH-1:0]   axis_in_tid;
    logic [AXIS_TDEST_WIDTH-1:0] axis_in_tdest;
    logic [AXIS_TUSER_WIDTH-1:0] axis_in_tuser;
    logic                        axis_in_tlast;
    logic                        axis_in_tvalid;
    logic                        axis_in_tready;

    logic [NUM_OUTPUTS*AXIS_BUS_WIDTH-1:0]   axis_out_tdata;
    logic [NUM_OUTPUTS*AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep;
    logic [NUM_OUTPUTS*AXIS_TID_WIDTH-1:0]   axis_out_tid;
    logic [NUM_OUTPUTS*AXIS_TDEST_WIDTH-1:0] axis_out_tdest;
    logic [NUM_OUTPUTS*AXIS_TUSER_WIDTH-1:0] axis_out_tuser;
    logic [NUM_OUTPUTS-1:0]                  axis_out_tlast;
    logic [NUM_OUTPUTS-1:0]                  axis_out_tvalid;
    logic [NUM_OUTPUTS-1:0]                  axis_out_tready;

    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output axis_in_tdata, axis_in_tkeep, axis_in_tid,
        output axis_in_tdest, axis_in_tuser, axis_in_tlast,
        output axis_in_tvalid,
        input  axis_in_tready,
        input  axis_out_tdata, axis_out_tkeep, axis_out_tid,
        input  axis_out_tdest, axis_out_tuser, axis_out_tlast,
        input  axis_out_tvalid,
        output axis_out_tready,
        input  drop_count
    );

    modport slave (
        input  axis_in_tdata, axis_in_tkeep, axis_in_tid,
        input  axis_in_tdest, axis_in_tuser, axis_in_tlast,
        input  axis_in_tvalid,
        output axis_in_tready,
        output axis_out_tdata, axis_out_tkeep, axis_out_tid,
        output axis_out_tdest, axis_out_tuser, axis_out_tlast,
        output axis_out_tvalid,
        input  axis_out_tready,
        output drop_count
    );
endinterface

// File: rtl/axi_stream_1_to_n_switch.sv
// One-to-N AXI-Stream switch routed by tdest range on the first beat of
// each packet, with one output register stage and optional unmatched drop.
`timescale 1ns/1ps
module axi_stream_1_to_n_switch #(
    parameter int NUM_OUTPUTS      = 4,
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_TID_WIDTH   = 1,
    parameter int AXIS_TDEST_WIDTH = 4,
    parameter int AXIS_TUSER_WIDTH = 1,
    parameter logic [NUM_OUTPUTS*AXIS_TDEST_WIDTH-1:0] ADDR_RANGE_LOW  = '0,
    parameter logic [NUM_OUTPUTS*AXIS_TDEST_WIDTH-1:0] ADDR_RANGE_HIGH = '1,
    parameter int DEFAULT_OUTPUT       = 0,
    parameter bit DROP_UNMATCHED       = 1'b0,
    parameter bit ENABLE_SECURE_OUTPUT = 1'b1,
    parameter int DROP_CNT_WIDTH       = 16
) (
    input logic aclk,
    input logic areset,
    axi_stream_1_to_n_switch_if.slave bus
);
    localparam int BW  = AXIS_BUS_WIDTH;
    localparam int KW  = AXIS_BUS_WIDTH / 8;
    localparam int IDW = AXIS_TID_WIDTH;
    localparam int TDW = AXIS_TDEST_WIDTH;
    localparam int UW  = AXIS_TUSER_WIDTH;
    localparam int IW  = $clog2(NUM_OUTPUTS);
    localparam logic [IW-1:0] DEF = IW'(DEFAULT_OUTPUT);

    logic                      r_valid;
    logic [IW-1:0]             r_route;
    logic [BW-1:0]             r_tdata;
    logic [KW-1:0]             r_tkeep;
    logic [IDW-1:0]            r_tid;
    logic [TDW-1:0]            r_tdest;
    logic [UW-1:0]             r_tuser;
    logic                      r_tlast;
    logic                      r_in_pkt;
    logic [IW-1:0]             r_pkt_route;
    logic                      r_dropping;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic          w_hit;
    logic [IW-1:0] w_match;
    logic          w_first;
    logic [IW-1:0] w_route;
    logic          w_drop;
    logic          w_out_rdy;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_drain;

    // Scan downwards so the lowest matching index is the last one written
    always_comb begin
        w_hit   = 1'b0;
        w_match = DEF;
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (bus.axis_in_tdest >= ADDR_RANGE_LOW[i*TDW +: TDW] &&
                bus.axis_in_tdest <= ADDR_RANGE_HIGH[i*TDW +: TDW]) begin
                w_hit   = 1'b1;
                w_match = IW'(i);
            end
        end
    end

    assign w_first    = !r_in_pkt;
    assign w_route    = w_first ? w_match : r_pkt_route;
    assign w_drop     = w_first ? (DROP_UNMATCHED && !w_hit) : r_dropping;
    assign w_out_rdy  = bus.axis_out_tready[r_route];
    assign w_drain    = r_valid && w_out_rdy;
    assign w_in_ready = !areset && (w_drop || !r_valid || w_out_rdy);
    assign w_accept   = bus.axis_in_tvalid && w_in_ready;

    assign bus.axis_in_tready = w_in_ready;
    assign bus.drop_count     = r_drop_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_valid     <= 1'b0;
            r_route     <= DEF;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tid       <= '0;
            r_tdest     <= '0;
            r_tuser     <= '0;
            r_tlast     <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_pkt_route <= DEF;
            r_dropping  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_in_pkt    <= !bus.axis_in_tlast;
                r_pkt_route <= w_route;
                r_dropping  <= w_drop;
            end
            if (w_accept && w_drop && w_first && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
            // Dropped beats bypass the register, which keeps draining
            if (w_accept && !w_drop) begin
                r_valid <= 1'b1;
                r_route <= w_route;
                r_tdata <= bus.axis_in_tdata;
                r_tkeep <= bus.axis_in_tkeep;
                r_tid   <= bus.axis_in_tid;
                r_tdest <= bus.axis_in_tdest;
                r_tuser <= bus.axis_in_tuser;
                r_tlast <= bus.axis_in_tlast;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.axis_out_tvalid = '0;
        bus.axis_out_tdata  = '0;
        bus.axis_out_tkeep  = '0;
        bus.axis_out_tid    = '0;
        bus.axis_out_tdest  = '0;
        bus.axis_out_tuser  = '0;
        bus.axis_out_tlast  = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            bus.axis_out_tvalid[i] = r_valid && (r_route == IW'(i));
            if (bus.axis_out_tvalid[i] || !ENABLE_SECURE_OUTPUT) begin
                bus.axis_out_tdata[i*BW +: BW]   = r_tdata;
                bus.axis_out_tkeep[i*KW +: KW]   = r_tkeep;
                bus.axis_out_tid[i*IDW +: IDW]   = r_tid;
                bus.axis_out_tdest[i*TDW +: TDW] = r_tdest;
                bus.axis_out_tuser[i*UW +: UW]   = r_tuser;
                bus.axis_out_tlast[i]            = r_tlast;
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_1_to_n_switch.sv
// Scoreboard bench for the 1-to-N AXI-Stream switch: random and directed
// packets checked against a range-table reference model.
`timescale 1ns/1ps
module tb_axi_stream_1_to_n_switch;
    localparam int NO = 4;
    localparam int BW = 64;
    localparam int KW = 8;
    localparam int TW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [NO*TW-1:0] LOWV  = {5'd12, 5'd8, 5'd4, 5'd0};
    localparam logic [NO*TW-1:0] HIGHV = {5'd15, 5'd11, 5'd7, 5'd3};

    typedef struct packed {
        logic [BW-1:0] data;
        logic [KW-1:0] keep;
        logic          id;
        logic [TW-1:0] dest;
        logic          user;
        logic          last;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_stream_1_to_n_switch_if #(
        .NUM_OUTPUTS(NO), .AXIS_BUS_WIDTH(BW), .AXIS_TID_WIDTH(1),
        .AXIS_TDEST_WIDTH(TW), .AXIS_TUSER_WIDTH(1), .DROP_CNT_WIDTH(CW)
    ) bus ();

    axi_stream_1_to_n_switch #(
        .NUM_OUTPUTS(NO), .AXIS_BUS_WIDTH(BW), .AXIS_TID_WIDTH(1),
        .AXIS_TDEST_WIDTH(TW), .AXIS_TUSER_WIDTH(1),
        .ADDR_RANGE_LOW(LOWV), .ADDR_RANGE_HIGH(HIGHV),
        .DEFAULT_OUTPUT(0), .DROP_UNMATCHED(1'b1),
        .ENABLE_SECURE_OUTPUT(1'b1), .DROP_CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_drops = 0;
    int lo_b[NO] = '{0, 4, 8, 12};
    int hi_b[NO] = '{3, 7, 11, 15};
    beat_t expq[NO][$];
    int log_out[$];
    int log_cyc[$];
    bit bp_mode = 1'b0;
    logic [NO-1:0] rdy_cfg = '1;
    logic [NO-1:0] stall_prev = '0;
    beat_t stall_beat[NO];

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic int ref_route(input int d);
        for (int i = 0; i < NO; i++)
            if (d >= lo_b[i] && d <= hi_b[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t slice(input int i);
        beat_t b;
        b.data = bus.axis_out_tdata[i*BW +: BW];
        b.keep = bus.axis_out_tkeep[i*KW +: KW];
        b.id   = bus.axis_out_tid[i];
        b.dest = bus.axis_out_tdest[i*TW +: TW];
        b.user = bus.axis_out_tuser[i];
        b.last = bus.axis_out_tlast[i];
        return b;
    endfunction

    // Output readiness: fixed pattern or random backpressure
    initial begin
        bus.axis_out_tready = '1;
        forever begin
            @(posedge aclk);
            #2;
            if (bp_mode) begin
                for (int i = 0; i < NO; i++)
                    bus.axis_out_tready[i] = ($urandom_range(0, 3) != 0);
            end else begin
                bus.axis_out_tready = rdy_cfg;
            end
        end
    end

    // Monitor: pops the scoreboard on each output handshake
    always @(negedge aclk) begin
        logic [NO-1:0] v;
        logic zero_bad;
        beat_t a;
        if (!areset) begin
            v = bus.axis_out_tvalid;
            zero_bad = 1'b0;
            for (int i = 0; i < NO; i++) begin
                a = slice(i);
                if (stall_prev[i])
                    check($sformatf("hold out%0d", i), {v[i], a},
                          {1'b1, stall_beat[i]});
                if (v[i] && bus.axis_out_tready[i]) begin
                    if (expq[i].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected beat out%0d: got %0h expected none",
                                 i, a);
                    end else begin
                        check($sformatf("beat out%0d", i), a, expq[i].pop_front());
                    end
                    log_out.push_back(i);
                    log_cyc.push_back(cyc);
                end else if (!v[i] && a != '0) begin
                    zero_bad = 1'b1;
                end
                stall_prev[i] = v[i] && !bus.axis_out_tready[i];
                stall_beat[i] = a;
            end
            check("onehot/secure", {($countones(v) <= 1), zero_bad}, {1'b1, 1'b0});
        end else begin
            stall_prev = '0;
        end
    end

    task automatic send_beat(input logic [TW-1:0] d, input logic last,
                             input int route, output int waits);
        beat_t e;
        logic acc;
        e.data = {$urandom, $urandom};
        e.keep = KW'($urandom);
        e.id   = 1'($urandom);
        e.dest = d;
        e.user = 1'($urandom);
        e.last = last;
        if (route >= 0) expq[route].push_back(e);
        bus.axis_in_tdata  = e.data;
        bus.axis_in_tkeep  = e.keep;
        bus.axis_in_tid    = e.id;
        bus.axis_in_tdest  = e.dest;
        bus.axis_in_tuser  = e.user;
        bus.axis_in_tlast  = e.last;
        bus.axis_in_tvalid = 1'b1;
        waits = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge aclk);
            acc = bus.axis_in_tready;
            @(posedge aclk);
            #1;
            waits++;
            if (waits > 2000) begin
                tests++;
                fails++;
                $display("FAIL input accept timeout: got waits %0d required <2000", waits);
                acc = 1'b1;
            end
        end
        bus.axis_in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int d, input int len, input int gap,
                            output int max_wait);
        int r;
        int w;
        logic [TW-1:0] bd;
        r = ref_route(d);
        if (r < 0 && exp_drops < CMAX) exp_drops++;
        max_wait = 0;
        for (int b = 0; b < len; b++) begin
            bd = (b == 0) ? d[TW-1:0] : TW'($urandom);
            send_beat(bd, b == len - 1, r, w);
            if (w > max_wait) max_wait = w;
            repeat ($urandom_range(0, gap)) begin
                @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        int left;
        n = 0;
        left = 1;
        while (left != 0 && n < 3000) begin
            left = 0;
            for (int i = 0; i < NO; i++) left += expq[i].size();
            if (left != 0) begin
                @(posedge aclk);
                #1;
                n++;
            end
        end
        check({name, " drained"}, left, 0);
    endtask

    initial begin
        int w;
        bus.axis_in_tdata  = '0;
        bus.axis_in_tkeep  = '0;
        bus.axis_in_tid    = '0;
        bus.axis_in_tdest  = '0;
        bus.axis_in_tuser  = '0;
        bus.axis_in_tlast  = 1'b0;
        bus.axis_in_tvalid = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset tvalid", bus.axis_out_tvalid, 0);
        check("reset drop_count", bus.drop_count, 0);
        check("reset tdata", bus.axis_out_tdata, 0);
        check("reset tlast", bus.axis_out_tlast, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("tready after reset", bus.axis_in_tready, 1);
        @(posedge aclk);
        #1;

        // 3-beat packet to output 1 in consecutive cycles
        log_out.delete();
        log_cyc.delete();
        send_pkt(5, 3, 0, w);
        repeat (3) begin @(posedge aclk); #1; end
        check("t1 beats", log_out.size(), 3);
        if (log_out.size() == 3) begin
            check("t1 routes", {log_out[0], log_out[1], log_out[2]}, {32'd1, 32'd1, 32'd1});
            check("t1 spacing", {log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]},
                  {32'd1, 32'd1});
        end

        // Back-to-back packets to different outputs, no bubble
        log_out.delete();
        log_cyc.delete();
        send_pkt(0, 2, 0, w);
        send_pkt(13, 1, 0, w);
        repeat (3) begin @(posedge aclk); #1; end
        check("t2 beats", log_out.size(), 3);
        if (log_out.size() == 3) begin
            check("t2 routes", {log_out[0], log_out[1], log_out[2]}, {32'd0, 32'd0, 32'd3});
            check("t2 spacing", {log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]},
                  {32'd1, 32'd1});
        end

        // Unmatched packet dropped while a beat sits stalled in the register
        rdy_cfg = '0;
        send_pkt(2, 1, 0, w);
        send_pkt(20, 4, 0, w);
        check("drop never stalls", w, 1);
        @(negedge aclk);
        check("drop_count after drop", bus.drop_count, 1);
        check("stalled beat held", bus.axis_out_tvalid, 4'b0001);
        @(posedge aclk);
        #1;
        rdy_cfg = '1;
        drain("drop");

        // Output 2 stalled for several cycles mid-packet
        rdy_cfg = 4'b1011;
        fork
            send_pkt(9, 3, 0, w);
            begin
                repeat (3) @(negedge aclk);
                check("bp input stalled", {bus.axis_in_tready, bus.axis_out_tvalid[2]},
                      {1'b0, 1'b1});
                repeat (3) @(posedge aclk);
                #1;
                rdy_cfg = '1;
            end
        join
        drain("backpressure");

        // Reset after beat 2 of a 4-beat packet
        send_pkt(9, 1, 0, w);
        drain("pre-reset");
        send_beat(5'd9, 1'b0, 2, w);
        send_beat(5'd9, 1'b0, 2, w);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        for (int i = 0; i < NO; i++) expq[i].delete();
        exp_drops = 0;
        @(negedge aclk);
        check("midreset tvalid", bus.axis_out_tvalid, 0);
        check("midreset drop_count", bus.drop_count, 0);
        check("midreset tready", bus.axis_in_tready, 1);
        @(posedge aclk);
        #1;
        log_out.delete();
        send_pkt(6, 1, 0, w);
        drain("post-reset");
        check("post-reset route", log_out.size() == 1 && log_out[0] == 1, 1);

        // Random traffic with random backpressure
        bp_mode = 1'b1;
        for (int p = 0; p < 200; p++)
            send_pkt($urandom_range(0, 31), $urandom_range(1, 4), 1, w);
        bp_mode = 1'b0;
        drain("random");
        @(negedge aclk);
        check("random drop_count", bus.drop_count, exp_drops);
        @(posedge aclk);
        #1;

        // Counter saturation
        for (int p = 0; p < 300; p++)
            send_pkt(16 + $urandom_range(0, 15), 1, 0, w);
        repeat (2) begin @(posedge aclk); #1; end
        @(negedge aclk);
        check("sat drop_count", bus.drop_count, 255);
        check("sat model", bus.drop_count, exp_drops);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
